// File: rtl/regfile_mp.sv
// Multi-ported register file with r0 hardwired to zero, a per-register pending scoreboard and a sequenced bulk clear.
// Reads are combinational (optional same-cycle write forwarding); writes/scoreboard/clear update on the rising edge.
module regfile_mp #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NRD    = 2,
   parameter int NWR    = 2,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                 clk,
   input  logic                 nRST,
   input  logic [NWR-1:0]       wr_en,
   input  logic [NWR*AW-1:0]    wr_idx,
   input  logic [NWR*XLEN-1:0]  wr_data,
   input  logic [NRD*AW-1:0]    rd_idx,
   output logic [NRD*XLEN-1:0]  rd_data,
   output logic [NRD-1:0]       rd_pend,
   input  logic                 sb_set,
   input  logic [AW-1:0]        sb_idx,
   input  logic                 clr_req,
   output logic                 clr_busy,
   output logic                 clr_done
);

   typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

   state_t            state, state_nxt;
   logic [AW-1:0]     cnt;
   logic [XLEN-1:0]   regs [NREGS];
   logic [NREGS-1:0]  pend;
   logic              idle;
   logic [NWR-1:0]    wr_act;
   logic              sb_act;
   logic [AW-1:0]     ridx;
   logic [XLEN-1:0]   rval;

   // Writes and scoreboard sets are only honoured while no clear is running.
   assign idle   = (state == IDLE);
   assign wr_act = wr_en & {NWR{idle}};
   assign sb_act = sb_set & idle & (sb_idx != '0);

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (clr_req) state_nxt = CLEAR;
         CLEAR:   if (cnt == AW'(NREGS - 1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      clr_busy = 1'b0;
      clr_done = 1'b0;
      case (state)
         CLEAR:   clr_busy = 1'b1;
         DONE:    begin clr_busy = 1'b1; clr_done = 1'b1; end
         default: ;
      endcase
   end

   // Later ports overwrite earlier ones, so the highest-numbered port wins a collision.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         cnt <= '0;
         for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      end else begin
         if (state == IDLE) begin
            cnt <= AW'(1);
         end else if (state == CLEAR) begin
            regs[cnt] <= '0;
            cnt       <= cnt + AW'(1);
         end
         for (int p = 0; p < NWR; p++)
            if (wr_act[p] && wr_idx[p*AW +: AW] != '0)
               regs[wr_idx[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
      end
   end

   // A new producer issued in the same cycle as a retiring write leaves the bit set.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         pend <= '0;
      end else if (idle && clr_req) begin
         pend <= '0;
      end else begin
         for (int p = 0; p < NWR; p++)
            if (wr_act[p]) pend[wr_idx[p*AW +: AW]] <= 1'b0;
         if (sb_act) pend[sb_idx] <= 1'b1;
      end
   end

   always_comb begin
      rd_data = '0;
      rd_pend = '0;
      ridx    = '0;
      rval    = '0;
      for (int r = 0; r < NRD; r++) begin
         ridx = rd_idx[r*AW +: AW];
         rval = regs[ridx];
         if (BYPASS != 0)
            for (int p = 0; p < NWR; p++)
               if (wr_act[p] && wr_idx[p*AW +: AW] == ridx) rval = wr_data[p*XLEN +: XLEN];
         if (ridx == '0) rval = '0;
         rd_data[r*XLEN +: XLEN] = rval;
         rd_pend[r]              = (ridx != '0) && pend[ridx];
      end
   end

endmodule
